// File: rtl/muldiv_sequencer.sv
// Sequencer for the HI/LO multiply/divide unit: launches the multiplier or divider,
// waits for completion, then writes HI/LO or reports divide-by-zero / timeout.
module muldiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int MEM_WAIT   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       mult_end,
    input  logic       div_end,
    input  logic       div_zero,
    output logic       mult_flag,
    output logic       div_flag,
    output logic       div_selector,
    output logic       mult_div,
    output logic       hi_write,
    output logic       lo_write,
    output logic       mdr_write,
    output logic       busy,
    output logic       done,
    output logic       exc_div0,
    output logic       timeout,
    output logic [5:0] cycles
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIVM = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;
    localparam int         WAIT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEMWAIT = 3'd1,
        S_KICK    = 3'd2,
        S_RUN     = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [5:0]          r_cycles;
    logic                r_mult_flag;
    logic                r_div_flag;
    logic                r_div_selector;
    logic                r_mult_div;
    logic                r_hi_write;
    logic                r_lo_write;
    logic                r_mdr_write;
    logic                r_busy;
    logic                r_done;
    logic                r_exc_div0;
    logic                r_timeout;

    logic                w_end;
    logic                w_zero;
    logic                w_budget_out;

    // Completion flags are qualified by the latched op so the idle unit is never heard.
    assign w_end        = (r_op == OP_MULT) ? mult_end : div_end;
    assign w_zero       = (r_op != OP_MULT) && div_zero;
    assign w_budget_out = (r_cycles == 6'(MAX_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op           <= OP_MULT;
            r_wait_cnt     <= '0;
            r_cycles       <= '0;
            r_mult_flag    <= 1'b0;
            r_div_flag     <= 1'b0;
            r_div_selector <= 1'b0;
            r_mult_div     <= 1'b0;
            r_hi_write     <= 1'b0;
            r_lo_write     <= 1'b0;
            r_mdr_write    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_exc_div0     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_mult_flag <= 1'b0;
            r_div_flag  <= 1'b0;
            r_hi_write  <= 1'b0;
            r_lo_write  <= 1'b0;
            r_mdr_write <= 1'b0;
            r_done      <= 1'b0;
            r_exc_div0  <= 1'b0;
            r_timeout   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start && (op != OP_ILL)) begin
                        r_op       <= op;
                        r_busy     <= 1'b1;
                        r_mult_div <= (op != OP_MULT);
                        if (op == OP_DIVM) begin
                            r_state        <= S_MEMWAIT;
                            r_div_selector <= 1'b1;
                            r_mdr_write    <= 1'b1;
                            r_wait_cnt     <= WAIT_W'(1);
                        end else begin
                            r_state        <= S_KICK;
                            r_div_selector <= 1'b0;
                            r_mult_flag    <= (op == OP_MULT);
                            r_div_flag     <= (op != OP_MULT);
                            r_cycles       <= '0;
                        end
                    end
                end

                S_MEMWAIT: begin
                    if (r_wait_cnt >= WAIT_W'(MEM_WAIT)) begin
                        r_state    <= S_KICK;
                        r_div_flag <= 1'b1;
                        r_cycles   <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end

                S_KICK: begin
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    if (r_cycles != 6'h3F) begin
                        r_cycles <= r_cycles + 6'd1;
                    end
                    // Divide-by-zero beats a coincident end; any end beats the budget.
                    if (w_zero) begin
                        r_state        <= S_IDLE;
                        r_exc_div0     <= 1'b1;
                        r_busy         <= 1'b0;
                        r_mult_div     <= 1'b0;
                        r_div_selector <= 1'b0;
                    end else if (w_end) begin
                        r_state    <= S_WRITE;
                        r_hi_write <= 1'b1;
                        r_lo_write <= 1'b1;
                        r_done     <= 1'b1;
                    end else if (w_budget_out) begin
                        r_state        <= S_IDLE;
                        r_timeout      <= 1'b1;
                        r_busy         <= 1'b0;
                        r_mult_div     <= 1'b0;
                        r_div_selector <= 1'b0;
                    end
                end

                S_WRITE: begin
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                    r_mult_div     <= 1'b0;
                    r_div_selector <= 1'b0;
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                    r_mult_div     <= 1'b0;
                    r_div_selector <= 1'b0;
                end
            endcase
        end
    end

    assign mult_flag    = r_mult_flag;
    assign div_flag     = r_div_flag;
    assign div_selector = r_div_selector;
    assign mult_div     = r_mult_div;
    assign hi_write     = r_hi_write;
    assign lo_write     = r_lo_write;
    assign mdr_write    = r_mdr_write;
    assign busy         = r_busy;
    assign done         = r_done;
    assign exc_div0     = r_exc_div0;
    assign timeout      = r_timeout;
    assign cycles       = r_cycles;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: cycle-exact checks of each operation,
// the priority corners, reset behaviour and total pulse counts.
module tb_muldiv_sequencer;

    localparam int MAX_CYCLES = 40;
    localparam int MEM_WAIT   = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       mult_end;
    logic       div_end;
    logic       div_zero;
    logic       mult_flag;
    logic       div_flag;
    logic       div_selector;
    logic       mult_div;
    logic       hi_write;
    logic       lo_write;
    logic       mdr_write;
    logic       busy;
    logic       done;
    logic       exc_div0;
    logic       timeout;
    logic [5:0] cycles;
    logic [16:0] all_outs;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0, n_exc = 0, n_tmo = 0, n_mflag = 0, n_dflag = 0, n_hi = 0, n_mdr = 0;

    muldiv_sequencer #(
        .MAX_CYCLES(MAX_CYCLES),
        .MEM_WAIT  (MEM_WAIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .mult_end    (mult_end),
        .div_end     (div_end),
        .div_zero    (div_zero),
        .mult_flag   (mult_flag),
        .div_flag    (div_flag),
        .div_selector(div_selector),
        .mult_div    (mult_div),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .mdr_write   (mdr_write),
        .busy        (busy),
        .done        (done),
        .exc_div0    (exc_div0),
        .timeout     (timeout),
        .cycles      (cycles)
    );

    always #5 clock = ~clock;

    assign all_outs = {mult_flag, div_flag, div_selector, mult_div, hi_write, lo_write,
                       mdr_write, busy, done, exc_div0, timeout, cycles};

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (done === 1'b1)      n_done++;
            if (exc_div0 === 1'b1)  n_exc++;
            if (timeout === 1'b1)   n_tmo++;
            if (mult_flag === 1'b1) n_mflag++;
            if (div_flag === 1'b1)  n_dflag++;
            if (hi_write === 1'b1)  n_hi++;
            if (mdr_write === 1'b1) n_mdr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00;
        mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
        step(2);
        chk("reset_outs", 32'(all_outs), 32'h0);
        reset = 1'b0;
        step(1);
        chk("idle_outs", 32'(all_outs), 32'h0);

        // Illegal op in IDLE is ignored
        start = 1'b1; op = 2'b11;
        step(1);
        start = 1'b0; op = 2'b00;
        chk("ill_outs", 32'(all_outs), 32'h0);
        step(1);
        chk("ill_outs2", 32'(all_outs), 32'h0);

        // MULT: mult_end at t+34, done at t+35, idle at t+36
        start = 1'b1; op = 2'b00;
        step(1);                                   // t+1
        start = 1'b0;
        chk("mul_kick_mflag", mult_flag, 1'b1);
        chk("mul_kick_dflag", div_flag, 1'b0);
        chk("mul_kick_mdiv", mult_div, 1'b0);
        chk("mul_kick_busy", busy, 1'b1);
        chk("mul_kick_cyc", cycles, 6'd0);
        step(1);                                   // t+2
        chk("mul_run_mflag", mult_flag, 1'b0);
        step(3);                                   // t+5
        start = 1'b1; op = 2'b01;
        step(1);                                   // t+6
        start = 1'b0; op = 2'b00;
        chk("mul_busy_start_dflag", div_flag, 1'b0);
        chk("mul_busy_start_cyc", cycles, 6'd4);
        chk("mul_busy_start_busy", busy, 1'b1);
        step(28);                                  // t+34
        chk("mul_cyc32", cycles, 6'd32);
        chk("mul_nodone_yet", done, 1'b0);
        mult_end = 1'b1;
        step(1);                                   // t+35
        mult_end = 1'b0;
        chk("mul_done", done, 1'b1);
        chk("mul_hi", hi_write, 1'b1);
        chk("mul_lo", lo_write, 1'b1);
        chk("mul_wr_mdiv", mult_div, 1'b0);
        chk("mul_wr_busy", busy, 1'b1);
        start = 1'b1; op = 2'b00;                  // start during WRITE is ignored
        step(1);                                   // t+36
        start = 1'b0;
        chk("mul_end_busy", busy, 1'b0);
        chk("mul_end_done", done, 1'b0);
        chk("mul_end_hi", hi_write, 1'b0);
        chk("mul_wr_start_ign", mult_flag, 1'b0);

        // DIVM: mdr_write at t+1, div_flag at t+3
        start = 1'b1; op = 2'b10;
        step(1);                                   // t+1
        start = 1'b0; op = 2'b00;
        chk("divm_mdr1", mdr_write, 1'b1);
        chk("divm_sel1", div_selector, 1'b1);
        chk("divm_mdiv1", mult_div, 1'b1);
        chk("divm_busy1", busy, 1'b1);
        chk("divm_dflag1", div_flag, 1'b0);
        step(1);                                   // t+2
        chk("divm_mdr2", mdr_write, 1'b0);
        chk("divm_sel2", div_selector, 1'b1);
        chk("divm_dflag2", div_flag, 1'b0);
        step(1);                                   // t+3
        chk("divm_dflag3", div_flag, 1'b1);
        chk("divm_sel3", div_selector, 1'b1);
        chk("divm_mdiv3", mult_div, 1'b1);
        step(1);                                   // t+4
        chk("divm_dflag4", div_flag, 1'b0);
        mult_end = 1'b1;                           // wrong unit's flag
        step(1);                                   // t+5
        mult_end = 1'b0;
        chk("divm_ign_mend", done, 1'b0);
        chk("divm_busy5", busy, 1'b1);
        step(1);                                   // t+6
        div_end = 1'b1;
        step(1);                                   // t+7
        div_end = 1'b0;
        chk("divm_done", done, 1'b1);
        chk("divm_hi", hi_write, 1'b1);
        chk("divm_sel_wr", div_selector, 1'b1);
        chk("divm_mdiv_wr", mult_div, 1'b1);
        step(1);                                   // t+8
        chk("divm_idle_busy", busy, 1'b0);
        chk("divm_idle_sel", div_selector, 1'b0);
        chk("divm_idle_mdiv", mult_div, 1'b0);

        // DIV with div_zero and div_end together at t+5
        start = 1'b1; op = 2'b01;
        step(1);                                   // t+1
        start = 1'b0; op = 2'b00;
        chk("div0_dflag", div_flag, 1'b1);
        chk("div0_sel", div_selector, 1'b0);
        chk("div0_mdiv", mult_div, 1'b1);
        step(4);                                   // t+5
        div_zero = 1'b1; div_end = 1'b1;
        step(1);                                   // t+6
        div_zero = 1'b0; div_end = 1'b0;
        chk("div0_exc", exc_div0, 1'b1);
        chk("div0_nodone", done, 1'b0);
        chk("div0_nohi", hi_write, 1'b0);
        chk("div0_busy", busy, 1'b0);
        chk("div0_mdiv_idle", mult_div, 1'b0);
        step(1);                                   // t+7
        chk("div0_exc_once", exc_div0, 1'b0);
        chk("div0_still_idle", busy, 1'b0);

        // DIV with div_end on the last budget cycle: completion wins
        start = 1'b1; op = 2'b01;
        step(1);
        start = 1'b0; op = 2'b00;
        step(40);                                  // t+41
        chk("prio_cyc39", cycles, 6'd39);
        div_end = 1'b1;
        step(1);                                   // t+42
        div_end = 1'b0;
        chk("prio_done", done, 1'b1);
        chk("prio_no_tmo", timeout, 1'b0);
        step(1);                                   // t+43
        chk("prio_idle", busy, 1'b0);
        chk("prio_no_tmo2", timeout, 1'b0);

        // DIV with no flags: timeout at t+42
        start = 1'b1; op = 2'b01;
        step(1);
        start = 1'b0; op = 2'b00;
        step(40);                                  // t+41
        chk("tmo_cyc39", cycles, 6'd39);
        chk("tmo_not_yet", timeout, 1'b0);
        step(1);                                   // t+42
        chk("tmo_pulse", timeout, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_nohi", hi_write, 1'b0);
        chk("tmo_nodone", done, 1'b0);
        step(1);                                   // t+43
        chk("tmo_once", timeout, 1'b0);
        start = 1'b1; op = 2'b00;
        step(1);                                   // t'+1
        start = 1'b0;
        chk("tmo_restart_mflag", mult_flag, 1'b1);
        chk("tmo_restart_busy", busy, 1'b1);

        // Reset mid-RUN with mult_end right after it
        step(9);                                   // t'+10
        reset = 1'b1;
        step(1);                                   // t'+11
        reset = 1'b0;
        mult_end = 1'b1;
        chk("rst_mid_outs", 32'(all_outs), 32'h0);
        step(1);                                   // t'+12
        mult_end = 1'b0;
        chk("rst_pending_end", 32'(all_outs), 32'h0);
        step(2);
        chk("rst_quiet", 32'(all_outs), 32'h0);

        chk("cnt_done", n_done, 3);
        chk("cnt_exc", n_exc, 1);
        chk("cnt_timeout", n_tmo, 1);
        chk("cnt_mult_flag", n_mflag, 2);
        chk("cnt_div_flag", n_dflag, 4);
        chk("cnt_hi_write", n_hi, 3);
        chk("cnt_mdr_write", n_mdr, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter MAX_CYCLES, default 40: RUN-state cycle budget before the operation is aborted as a timeout.
REQ-002 Parameter MEM_WAIT, default 2: memory-operand settle cycles for op DIVM.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request from ctrl_unit; sampled only in IDLE.
REQ-006 op  in  2  operation select: 00 MULT, 01 DIV (A/B regs), 10 DIVM (MEM_out/MDR_out operands), 11 illegal.
REQ-007 mult_end  in  1  multiplier completion flag (ciclos_end).
REQ-008 div_end  in  1  divider completion flag (ciclos_end_01).
REQ-009 div_zero  in  1  divider divide-by-zero flag (Div_0_Excp).
REQ-010 mult_flag  out  1  one-cycle start pulse to multiplicador.
REQ-011 div_flag  out  1  one-cycle start pulse to divisor.
REQ-012 div_selector  out  1  1 selects memory operands for divisor (mux_divA pair).
REQ-013 mult_div  out  1  HI/LO source mux select: 0 multiplier, 1 divider.
REQ-014 hi_write, lo_write  out  1 each  HI and LO register write enables.
REQ-015 mdr_write  out  1  MDR load enable during DIVM operand fetch.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 exc_div0  out  1  one-cycle divide-by-zero exception pulse to ctrl_unit.
REQ-019 timeout  out  1  one-cycle abort pulse when the budget expires.
REQ-020 cycles  out  6  RUN cycle counter, debug visibility.

Function
REQ-021 States SHALL be IDLE, MEMWAIT, KICK, RUN, WRITE; all outputs are registered from the state/latched op, no combinational input-to-output paths.
REQ-022 IDLE: start=1 with op 00/01 latches op and moves to KICK next cycle; op 10 moves to MEMWAIT; op 11 is ignored (stay IDLE, no pulse).
REQ-023 start while busy=1 SHALL be ignored, including in the WRITE cycle.
REQ-024 MEMWAIT: div_selector=1, mdr_write=1 in the first MEMWAIT cycle only; after exactly MEM_WAIT cycles go to KICK.
REQ-025 KICK: exactly one cycle; mult_flag=1 for MULT, div_flag=1 for DIV/DIVM; cycles cleared to 0; next state RUN.
REQ-026 div_selector SHALL stay 1 from MEMWAIT through WRITE for DIVM, 0 for other ops.
REQ-027 mult_div SHALL equal (op!=MULT) from KICK through WRITE, and be 0 in IDLE.
REQ-028 RUN: cycles increments by 1 per RUN cycle, saturating at 63; MULT watches mult_end only, DIV/DIVM watch div_end and div_zero only.
REQ-029 RUN, relevant end flag=1 -> WRITE next cycle.
REQ-030 RUN, div_zero=1 -> exc_div0 pulse next cycle, return to IDLE, no HI/LO write; div_zero has priority over a coincident div_end.
REQ-031 RUN, cycles==MAX_CYCLES-1 with no end/zero flag -> timeout pulse next cycle, return to IDLE, no write; an end flag in that same cycle takes priority over the timeout.
REQ-032 WRITE: one cycle, hi_write=lo_write=1, done=1; next state IDLE.
REQ-033 Latency: start at cycle t, KICK at t+1, first RUN at t+2; end flag seen at RUN cycle r -> WRITE/done at r+1, new start accepted at r+2; DIVM adds MEM_WAIT cycles before KICK.
REQ-034 done, exc_div0, and timeout SHALL be mutually exclusive, and each SHALL fire at most once per accepted start.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE from any state, including mid-RUN and in WRITE.
REQ-036 After reset: every output is 0, cycles=0, latched op=00.
REQ-037 A pending end flag SHALL NOT produce a write or pulse after reset.

Verification
REQ-038 MULT: start, op=00 at t; mult_end at t+34 -> mult_flag at t+1, hi/lo_write and done at t+35, mult_div=0, busy low at t+36.
REQ-039 DIVM: start, op=10 at t -> mdr_write at t+1, div_flag at t+3, div_selector=1 and mult_div=1 held until done.
REQ-040 DIV: start, op=01, div_zero and div_end together at t+5 -> exc_div0 at t+6, no hi/lo_write, IDLE at t+6.
REQ-041 Timeout: DIV with no flags -> timeout pulse at t+2+MAX_CYCLES (t+42 with default), no write; start at t+43 is accepted.
REQ-042 start asserted during RUN, and op=11 in IDLE -> both ignored, with no state change and no extra pulses.
REQ-043 Reset at t+10 of a MULT, mult_end at t+11 -> all outputs 0 from t+11, no done or write.
